iterative_shifter: RTL
======================

// Module: iterative_shifter
// PURPOSE
//  Multi-cycle shift unit for the MIPS datapath. Generalises the fixed shift-left-by-2 immediate path.
//  Supports variable shift amounts and four modes: SLL, SRL, SRA and ROTR.
//  Shifts up to STEP bits per cycle, so the logic is a small one-step shifter instead of a full barrel shifter.
//  Sits beside the ALU; the control FSM stalls on busy and captures result on done.
// PARAMETERS
//  WIDTH    32               data width in bits; power of two, >= 4
//  SHAMT_W  $clog2(WIDTH)    width of the shift-amount port
//  STEP     4                maximum bits shifted per cycle; power of two, 1..WIDTH
// PORTS
//  clk      in   1        single clock, rising edge
//  rst_n    in   1        asynchronous, active-low reset
//  start    in   1        request; sampled only when busy=0
//  op       in   2        00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right)
//  shamt    in   SHAMT_W  shift amount, 0..WIDTH-1
//  data_in  in   WIDTH    operand
//  busy     out  1        high while an operation is in progress
//  done     out  1        one-cycle pulse; result is valid in the same cycle
//  result   out  WIDTH    shifted value; held from done until the next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy=0, done=0, result=0; internal regs cleared.
//  States: IDLE, SHIFT, DONE.
//  Start acceptance: at an edge with start=1 in IDLE or DONE:
//   - latch data_in, op, shamt into acc, op_r, rem;
//   - if shamt==0, go to DONE; otherwise go to SHIFT.
//  SHIFT, each edge:
//   - k = (rem > STEP) ? STEP : rem;
//   - acc = step(acc, op_r, k); rem = rem - k;
//   - if the new rem==0, go to DONE; else stay in SHIFT.
//  DONE: done=1 and result=acc for exactly one cycle.
//   - start=1 in DONE is accepted (back-to-back).
//   - otherwise go to IDLE; result is held.
//  result register updates only on the edge entering DONE.
//  busy=1 exactly while state==SHIFT.
//  Latency: done is high in the cycle following edge 1+ceil(shamt/STEP) after the accepting edge.
//   - shamt=0: 1 edge; WIDTH=32, STEP=4, shamt=31: 9 edges.
//  start while busy=1 is ignored; no queuing and no error flag.
//  Inputs are don't-care except at the accepting edge.
//  Arithmetic rules:
//   - SLL fills zeros at the LSB; SRL fills zeros at the MSB.
//   - SRA replicates acc[WIDTH-1] (sign is preserved every step).
//   - ROTR wraps the LSBs into the MSBs.
//   - shamt is used modulo WIDTH (port width guarantees this).
//  Reset asserted mid-SHIFT or mid-DONE aborts immediately to the reset values; no done pulse.
//  op=ROTR with shamt=0 returns data_in unchanged, as every op does.
// STRUCTURE
//  Package shifter_pkg holds:
//   - localparams OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROTR=2'b11;
//   - state encoding ST_IDLE, ST_SHIFT, ST_DONE (2 bits).
//  Sub-module shift_step: combinational, params WIDTH and STEP.
//   - ports: din[WIDTH], op[2], k[$clog2(STEP)+1], dout[WIDTH].
//   - shifts din by k in 0..STEP.
//  Top-level contents: FSM, rem counter, acc/op_r/result registers, one shift_step instance.
// TESTING  (WIDTH=32, STEP=4; edge 0 = accepting edge)
//  1. SLL, data 32'h0000000F, shamt 2 -> result 32'h0000003C; done after edge 2; busy high one cycle.
//  2. SRA, data 32'hFFFFFFF0, shamt 4 -> 32'hFFFFFFFF after edge 2.
//     Same test with data 32'h70000000, shamt 5 -> 32'h03800000 after edge 3.
//  3. SRL, data 32'h80000000, shamt 31 -> 32'h00000001 after edge 9.
//     busy high for 8 cycles; done high for exactly 1 cycle.
//  4. ROTR, data 32'h12345678, shamt 8 -> 32'h78123456 after edge 3.
//     Then start an SLL in the DONE cycle: accepted, and its result is correct.
//  5. SLL, data 32'd4, shamt 0 -> 32'd4 after edge 1.
//     During a shamt=31 op, pulse start with new data: ignored; the original result is unchanged.
//  6. Drop rst_n at edge 3 of a shamt=20 op -> busy, done and result are 0 at once, no done pulse.
//     After release, SLL of 32'h12345678 by 4 -> 32'h23456780.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared constants for the iterative shifter: op encodings and FSM states.
// Imported by the shift_step datapath and the iterative_shifter top.
package shifter_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-step combinational shifter: shifts din by k (0..STEP) in mode op.
// Ports: din[WIDTH], op[2], k[$clog2(STEP)+1] in; dout[WIDTH] out.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int KW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] dout
);

  // Rotate via a doubled word: the low half after a right
  // shift holds the wrapped LSBs, and k=0 needs no special case.
  logic [2*WIDTH-1:0] rot;
  assign rot = {din, din} >> k;

  always_comb begin
    dout = din;
    unique case (1'b1)
      (op == OP_SLL):  dout = din << k;
      (op == OP_SRL):  dout = din >> k;
      (op == OP_SRA):  dout = $signed(din) >>> k;
      (op == OP_ROTR): dout = rot[WIDTH-1:0];
      default:         dout = din;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit shifting at most STEP bits per cycle.
// Ports: clk, rst_n, start, op[2], shamt[SHAMT_W], data_in[WIDTH] in;
//        busy, done, result[WIDTH] out.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int KW = $clog2(STEP) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic [KW-1:0]      k;
  logic [SHAMT_W-1:0] rem_nx;
  logic [WIDTH-1:0]   step_out;

  // Clamp this cycle's shift to STEP bits.
  always_comb begin
    if (int'(rem_q) > STEP) k = KW'(STEP);
    else                    k = KW'(rem_q);
  end

  assign rem_nx = rem_q - SHAMT_W'(k);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .din  (acc_q),
    .op   (op_q),
    .k    (k),
    .dout (step_out)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    rem_d   = rem_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          acc_d = data_in;
          op_d  = op;
          rem_d = shamt;
          if (shamt == '0) begin
            state_d = ST_DONE;
            res_d   = data_in;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d = step_out;
        rem_d = rem_nx;
        if (rem_nx == '0) begin
          state_d = ST_DONE;
          res_d   = step_out;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign result = res_q;

endmodule
